fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-002 SHALL have port reset, input, 1: synchronous, active-high; sampled only on the rising clk edge.
REQ-003 SHALL have port loadPC, input, 1: branch/jump redirect request from write-back; only logic 1 acts, 0/x/z mean no redirect.
REQ-004 SHALL have port address, input, 6: redirect target, valid when loadPC=1.
REQ-005 SHALL have port HALTED, input, 1: halt request from write-back; only logic 1 acts.
REQ-006 SHALL have port stall, input, 1: downstream cannot accept a new instruction this cycle.
REQ-007 SHALL have port instr_in, input, 16: instruction memory read data, one-cycle synchronous latency from instr_addr.
REQ-008 SHALL have port instr_addr, output, 6: instruction memory read address, combinational.
REQ-009 SHALL have port instr_out, output, 16: registered instruction to decode.
REQ-010 SHALL have port instr_valid, output, 1: instr_out holds a live instruction.
REQ-011 SHALL have port pc_out, output, 6: address instr_out was fetched from.
REQ-012 SHALL have port halted_out, output, 1: fetch is frozen in HALT.
REQ-013 SHALL have port fetch_count, output, 16: number of instructions delivered since reset.

Function
REQ-014 SHALL hold internal registers pc[5:0] (next address to issue), req_pc[5:0] (address issued last cycle), req_valid (1 when instr_in is usable this cycle), state in {RUN, FLUSH, HALT}.
REQ-015 SHALL define stall_eff = stall AND instr_valid; stall when instr_valid=0 is ignored.
REQ-016 SHALL drive instr_addr = req_pc when stall_eff=1, else pc.
REQ-017 SHALL apply per-edge priority: reset > HALTED > loadPC > stall_eff > normal advance.
REQ-018 RUN, normal advance: req_pc <= pc, req_valid <= 1, pc <= pc+1 mod 64 (63 wraps to 0); if req_valid=1 then instr_out <= instr_in, pc_out <= req_pc, instr_valid <= 1, fetch_count increments; if req_valid=0 then instr_valid <= 0.
REQ-019 RUN, stall_eff=1: pc, req_pc, req_valid, instr_out, pc_out, instr_valid, fetch_count all hold.
REQ-020 loadPC=1 in RUN or FLUSH (including during stall): pc <= address, req_valid <= 0, instr_valid <= 0, state <= FLUSH; the held/in-flight instruction is discarded.
REQ-021 FLUSH without new loadPC/HALTED: req_pc <= pc, req_valid <= 1, pc <= pc+1 mod 64, instr_valid stays 0, state <= RUN.
REQ-022 Redirect latency: loadPC sampled at edge k -> instr_valid=1, pc_out=address, instr_out=mem[address] after edge k+2.
REQ-023 HALTED=1 in any state: state <= HALT, instr_valid <= 0, req_valid <= 0, halted_out <= 1; pc, pc_out, instr_out, fetch_count freeze; HALTED beats simultaneous loadPC.
REQ-024 HALT SHALL be exited only by reset; loadPC, stall, HALTED ignored there.
REQ-025 fetch_count SHALL saturate at 16'hFFFF, not wrap.
REQ-026 instr_addr in HALT SHALL equal the frozen pc.

Reset
REQ-027 reset=1 at an edge: state <= RUN, pc <= 0, req_pc <= 0, req_valid <= 0, instr_out <= 0, pc_out <= 0, instr_valid <= 0, halted_out <= 0, fetch_count <= 0; overrides any state, including mid-stall, FLUSH or HALT.
REQ-028 First instruction after reset release: instr_valid=1, pc_out=0, instr_out=mem[0] after the second edge with reset=0.

Verification
REQ-029 Reset, mem[i]=16'h1000+i, stall=0 -> pc_out 0,1,2,... on consecutive edges from edge 2, instr_out matches, fetch_count tracks count.
REQ-030 stall=1 for 3 cycles while pc_out=5 -> pc_out=5, instr_out=16'h1005, fetch_count frozen; after release pc_out=6 next edge, no instruction lost or duplicated.
REQ-031 loadPC=1, address=6'd40 at edge k -> instr_valid=0 after k and k+1; pc_out=40, instr_out=16'h1028 after k+2; then 41,42.
REQ-032 Sequential run from 62 -> pc_out 62,63,0,1 with no bubble.
REQ-033 HALTED=1 together with loadPC=1 -> halted_out=1, instr_valid=0, pc_out frozen, loadPC ignored for 10 cycles; reset -> REQ-028 behaviour.
REQ-034 Run fetch_count to 16'hFFFE, deliver 3 more -> fetch_count stays 16'hFFFF.

Source files
------------

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch unit bus: write-back redirect/halt, instruction memory port, decode-side outputs
interface fetch_unit_if;
    logic        loadPC;
    logic [5:0]  address;
    logic        HALTED;
    logic        stall;
    logic [15:0] instr_in;
    logic [5:0]  instr_addr;
    logic [15:0] instr_out;
    logic        instr_valid;
    logic [5:0]  pc_out;
    logic        halted_out;
    logic [15:0] fetch_count;

    // master is the fetch unit itself; slave is the surrounding pipeline and memory
    modport master (
        input  loadPC, address, HALTED, stall, instr_in,
        output instr_addr, instr_out, instr_valid, pc_out, halted_out, fetch_count
    );

    modport slave (
        output loadPC, address, HALTED, stall, instr_in,
        input  instr_addr, instr_out, instr_valid, pc_out, halted_out, fetch_count
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch with one-cycle synchronous memory, stall, redirect flush and halt
module fetch_unit (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);
    typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_HALT} state_t;

    state_t      r_state;
    logic [5:0]  r_pc;
    logic [5:0]  r_req_pc;
    logic        r_req_valid;
    logic [15:0] r_instr_out;
    logic [5:0]  r_pc_out;
    logic        r_instr_valid;
    logic        r_halted;
    logic [15:0] r_fetch_count;
    logic        w_stall_eff;

    // A stall only matters while an instruction is actually being held for decode.
    assign w_stall_eff     = bus.stall & r_instr_valid;
    // Re-issue the in-flight address while stalled so instr_in still carries it on release.
    assign bus.instr_addr  = w_stall_eff ? r_req_pc : r_pc;
    assign bus.instr_out   = r_instr_out;
    assign bus.instr_valid = r_instr_valid;
    assign bus.pc_out      = r_pc_out;
    assign bus.halted_out  = r_halted;
    assign bus.fetch_count = r_fetch_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_RUN;
            r_pc          <= 6'd0;
            r_req_pc      <= 6'd0;
            r_req_valid   <= 1'b0;
            r_instr_out   <= 16'd0;
            r_pc_out      <= 6'd0;
            r_instr_valid <= 1'b0;
            r_halted      <= 1'b0;
            r_fetch_count <= 16'd0;
        end else if (r_state != ST_HALT) begin
            if (bus.HALTED == 1'b1) begin
                r_state       <= ST_HALT;
                r_instr_valid <= 1'b0;
                r_req_valid   <= 1'b0;
                r_halted      <= 1'b1;
            end else if (bus.loadPC == 1'b1) begin
                r_state       <= ST_FLUSH;
                r_pc          <= bus.address;
                r_req_valid   <= 1'b0;
                r_instr_valid <= 1'b0;
            end else if (r_state == ST_FLUSH) begin
                r_state       <= ST_RUN;
                r_req_pc      <= r_pc;
                r_req_valid   <= 1'b1;
                r_pc          <= r_pc + 6'd1;
                r_instr_valid <= 1'b0;
            end else if (!w_stall_eff) begin
                r_req_pc    <= r_pc;
                r_req_valid <= 1'b1;
                r_pc        <= r_pc + 6'd1;
                if (r_req_valid) begin
                    r_instr_out   <= bus.instr_in;
                    r_pc_out      <= r_req_pc;
                    r_instr_valid <= 1'b1;
                    if (r_fetch_count != 16'hFFFF) begin
                        r_fetch_count <= r_fetch_count + 16'd1;
                    end
                end else begin
                    r_instr_valid <= 1'b0;
                end
            end
        end
    end
endmodule
